// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
package uart_arb_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, DRAIN} arb_state_e;

  localparam logic [3:0] NBITS_RST = 4'd8;
  localparam int         GRANT_W   = 3;

  // Round-robin successor of a winner index, wrapping at n requesters.
  function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/TX-side bundle of the UART TX arbiter.
// slave: the arbiter itself; master: the requesters plus the UART TX.
interface uart_tx_arbiter_if import uart_arb_pkg::*; #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [3:0]         nbits_cfg;
  logic [N_REQ-1:0]   ack;
  logic               busy;
  logic [GRANT_W-1:0] grant_id;
  logic               TxEn;
  logic [7:0]         TxData;
  logic [3:0]         NBits;
  logic               TxDone;
  logic               tmo_err;

  modport master (
    output req, req_data, nbits_cfg, TxDone,
    input  ack, busy, grant_id, TxEn, TxData, NBits, tmo_err
  );

  modport slave (
    input  req, req_data, nbits_cfg, TxDone,
    output ack, busy, grant_id, TxEn, TxData, NBits, tmo_err
  );
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, circularly.
// The pointer register lives in the parent.
module uart_rr_arbiter import uart_arb_pkg::*; #(
  parameter int N_REQ = 4
)(
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [N_REQ-1:0]   gnt,
  output logic [GRANT_W-1:0] idx
);

  // Scan N_REQ slots starting from ptr; the first hit wins.
  always_comb begin
    int  j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = GRANT_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared UART TX serializer.
// Optional macro UART_ARB_TIMEOUT_EN adds a per-state watchdog that aborts a
// stuck frame to IDLE without ack and pulses tmo_err.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int N_REQ      = 4,
  parameter int EN_CYCLES  = 2,
  parameter int TMO_CYCLES = 1 << 20
)(
  input logic              Clk,
  input logic              Rst,
  uart_tx_arbiter_if.slave bus
);

  arb_state_e         state_q;
  logic [GRANT_W-1:0] ptr_q, gid_q, rr_idx;
  logic [N_REQ-1:0]   gnt_q, ack_q, rr_gnt;
  logic               txen_q, tmo_err_q, tmo_hit;
  logic [7:0]         txdata_q;
  logic [3:0]         nbits_q;
  logic [31:0]        en_cnt;
  logic               launch_end, send_end, drain_end;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  assign launch_end = (state_q == LAUNCH) && (en_cnt == 32'(EN_CYCLES - 1));
  assign send_end   = (state_q == SEND)   && bus.TxDone;
  assign drain_end  = (state_q == DRAIN)  && !bus.TxDone;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // A normal transition in the same cycle takes precedence over the watchdog.
  assign tmo_hit = (state_q != IDLE) && !(launch_end || send_end || drain_end) &&
                   (tmo_cnt == 32'(TMO_CYCLES - 1));

  // Cycles spent in the current non-IDLE state; restarts on every state change.
  always_ff @(posedge Clk) begin
    if (Rst || state_q == IDLE || launch_end || send_end || drain_end || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Sequencer: grant in IDLE, strobe TxEn, wait for TxDone high then low.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      txen_q    <= 1'b0;
      txdata_q  <= '0;
      nbits_q   <= NBITS_RST;
      en_cnt    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      ack_q     <= '0;
      tmo_err_q <= 1'b0;
      if (tmo_hit) begin
        state_q   <= IDLE;
        txen_q    <= 1'b0;
        tmo_err_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: if (|bus.req) begin
            state_q  <= LAUNCH;
            gid_q    <= rr_idx;
            gnt_q    <= rr_gnt;
            ptr_q    <= next_ptr(rr_idx, N_REQ);
            txdata_q <= bus.req_data[8*rr_idx +: 8];
            nbits_q  <= bus.nbits_cfg;
            txen_q   <= 1'b1;
            en_cnt   <= '0;
          end
          LAUNCH: if (launch_end) begin
            txen_q  <= 1'b0;
            state_q <= SEND;
          end else begin
            en_cnt <= en_cnt + 1'b1;
          end
          SEND: if (send_end) begin
            ack_q   <= gnt_q;
            state_q <= DRAIN;
          end
          DRAIN: if (drain_end) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.grant_id = gid_q;
  assign bus.TxEn     = txen_q;
  assign bus.TxData   = txdata_q;
  assign bus.NBits    = nbits_q;
  assign bus.tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the watchdog step runs only when
// UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  logic Clk = 1'b0;
  logic Rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .EN_CYCLES(2), .TMO_CYCLES(64)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  // One complete frame from IDLE with req already presented; hold = cycles TxDone stays high after ack.
  task automatic frame(input int id, input logic [7:0] data, input logic [3:0] nb, input int hold);
    tick();
    chk("grant_id", 32'(bus.grant_id), 32'(id));
    chk("txen_c1",  32'(bus.TxEn),     32'd1);
    chk("txdata",   32'(bus.TxData),   32'(data));
    chk("nbits",    32'(bus.NBits),    32'(nb));
    chk("busy_on",  32'(bus.busy),     32'd1);
    tick();
    chk("txen_c2",  32'(bus.TxEn),     32'd1);
    tick();
    chk("txen_off", 32'(bus.TxEn),     32'd0);
    chk("ack_pre",  32'(bus.ack),      32'd0);
    bus.TxDone = 1'b1;
    tick();
    chk("ack",      32'(bus.ack),      32'(1 << id));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("drain_ack",  32'(bus.ack),  32'd0);
      chk("drain_busy", 32'(bus.busy), 32'd1);
    end
    bus.TxDone = 1'b0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ack",  32'(bus.ack),  32'd0);
  endtask

  initial begin
    Rst           = 1'b1;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.nbits_cfg = 4'd8;
    bus.TxDone    = 1'b0;
    do_reset();

    // Reset state
    chk("rst_ack",    32'(bus.ack),      32'd0);
    chk("rst_busy",   32'(bus.busy),     32'd0);
    chk("rst_gid",    32'(bus.grant_id), 32'd0);
    chk("rst_txen",   32'(bus.TxEn),     32'd0);
    chk("rst_txdata", 32'(bus.TxData),   32'd0);
    chk("rst_nbits",  32'(bus.NBits),    32'd8);
    chk("rst_tmo",    32'(bus.tmo_err),  32'd0);

    // 1: single request from requester 0
    bus.req_data = 32'h000000A5;
    bus.req      = 4'b0001;
    frame(0, 8'hA5, 4'd8, 1);
    bus.req = '0;
    tick();
    chk("t1_idle", 32'(bus.busy), 32'd0);

    // 2: all requesting, round-robin order 0,1,2,3,0
    do_reset();
    bus.req_data  = 32'h13121110;
    bus.nbits_cfg = 4'd7;
    bus.req       = 4'b1111;
    frame(0, 8'h10, 4'd7, 1);
    frame(1, 8'h11, 4'd7, 1);
    frame(2, 8'h12, 4'd7, 1);
    frame(3, 8'h13, 4'd7, 1);
    frame(0, 8'h10, 4'd7, 1);

    // 3: TxDone held 10 cycles after ack keeps DRAIN; next grant only after it falls
    frame(1, 8'h11, 4'd7, 10);
    frame(2, 8'h12, 4'd7, 1);
    bus.req = '0;

    // 4: requester 2 arrives mid-frame; ignored until IDLE, captured values stay put
    do_reset();
    bus.req_data  = 32'h000000A5;
    bus.nbits_cfg = 4'd7;
    bus.req       = 4'b0001;
    tick();
    chk("t4_gid0",  32'(bus.grant_id), 32'd0);
    chk("t4_data0", 32'(bus.TxData),   32'hA5);
    bus.req              = 4'b0101;
    bus.req_data[23:16]  = 8'hC3;
    bus.req_data[7:0]    = 8'h5A;
    bus.nbits_cfg        = 4'hF;
    tick();
    chk("t4_gid_hold",   32'(bus.grant_id), 32'd0);
    chk("t4_data_hold",  32'(bus.TxData),   32'hA5);
    chk("t4_nbits_hold", 32'(bus.NBits),    32'd7);
    tick();
    chk("t4_send_data",  32'(bus.TxData),   32'hA5);
    bus.TxDone = 1'b1;
    tick();
    chk("t4_ack0",       32'(bus.ack),      32'b0001);
    chk("t4_ack_data",   32'(bus.TxData),   32'hA5);
    bus.req    = 4'b0100;
    bus.TxDone = 1'b0;
    tick();
    chk("t4_idle",       32'(bus.busy),     32'd0);
    frame(2, 8'hC3, 4'hF, 1);
    bus.req = '0;

    // 5: reset during SEND aborts with no ack and restores priority to 0
    do_reset();
    bus.req_data  = 32'h44332211;
    bus.nbits_cfg = 4'd5;
    bus.req       = 4'b0010;
    tick();
    chk("t5_gid1",  32'(bus.grant_id), 32'd1);
    chk("t5_nbits", 32'(bus.NBits),    32'd5);
    tick();
    tick();
    chk("t5_send",  32'(bus.TxEn),     32'd0);
    bus.TxDone = 1'b1;
    Rst        = 1'b1;
    tick();
    Rst        = 1'b0;
    bus.TxDone = 1'b0;
    chk("t5_ack",    32'(bus.ack),      32'd0);
    chk("t5_busy",   32'(bus.busy),     32'd0);
    chk("t5_gid",    32'(bus.grant_id), 32'd0);
    chk("t5_txen",   32'(bus.TxEn),     32'd0);
    chk("t5_txdata", 32'(bus.TxData),   32'd0);
    chk("t5_nbits8", 32'(bus.NBits),    32'd8);
    bus.req = 4'b0011;
    frame(0, 8'h11, 4'd5, 1);
    bus.req = '0;

`ifdef UART_ARB_TIMEOUT_EN
    // 6: TxDone stuck low; watchdog aborts after 64 cycles in SEND
    do_reset();
    bus.req_data = 32'h000000A5;
    bus.req      = 4'b0001;
    tick();
    tick();
    tick();
    chk("t6_send", 32'(bus.TxEn), 32'd0);
    bus.req = '0;
    for (int i = 0; i < 63; i++) tick();
    chk("t6_tmo_pre",  32'(bus.tmo_err), 32'd0);
    chk("t6_busy_pre", 32'(bus.busy),    32'd1);
    tick();
    chk("t6_tmo",      32'(bus.tmo_err), 32'd1);
    chk("t6_idle",     32'(bus.busy),    32'd0);
    chk("t6_noack",    32'(bus.ack),     32'd0);
    tick();
    chk("t6_tmo_off",  32'(bus.tmo_err), 32'd0);
`else
    tick();
    chk("tmo_tied", 32'(bus.tmo_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
